i2c_addr_decoder: RTL and testbench
===================================

Name: i2c_addr_decoder

Overview:
Parametrised I2C slave front end. It synchronises and glitch-filters raw SCL/SDA, and detects START, repeated START and STOP. After each START it shifts in the first byte and matches its 7-bit address against NUM_ADDR programmable device addresses. Its results feed the slave controller FSM: match index, R/W bit and a byte-valid strobe.

Parameters:
NUM_ADDR, 3, number of device-address slots (1..16)
SYNC_STAGES, 2, metastability flops per line (>=2)
FILTER_LEN, 3, consecutive equal synced samples needed before a filtered line changes (>=1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
scl  input  1  raw I2C clock line
sda_in  input  1  raw I2C data line
device_addr  input  NUM_ADDR*7  packed slot addresses; slot i = bits [7i+6:7i]
starting_byte  output  8  first byte captured after the latest START
rw_mode  output  1  starting_byte[0], held
address_match  output  1  level: the captured address matched a slot
match_idx  output  $clog2(NUM_ADDR+1)  0 = no match, i+1 = slot i matched
addr_valid  output  1  one-cycle pulse when the 8th address bit is sampled
start_found  output  1  one-cycle pulse on START or repeated START
stop_found  output  1  one-cycle pulse on STOP
bus_busy  output  1  level, high from START until STOP
general_call  output  1  see Optional Feature

Behaviour:
- Reset values: all outputs 0. Synchroniser flops and filtered lines reset to 1 (idle bus). FSM resets to IDLE.
- Line filter, per line:
  - SYNC_STAGES flop chain feeds a sample counter.
  - The filtered value takes the synced value only after FILTER_LEN consecutive cycles of agreement.
  - Any disagreement restarts the count.
  - Pulses shorter than FILTER_LEN cycles are never seen.
- Edges:
  - Filtered values are registered once more as *_d.
  - START: scl_f = scl_d = 1 and sda_d = 1, sda_f = 0.
  - STOP: scl_f = scl_d = 1 and sda_d = 0, sda_f = 1.
  - SCL rise: scl_d = 0, scl_f = 1.
- Pulse timing: start_found/stop_found are registered pulses. They assert exactly SYNC_STAGES+FILTER_LEN+1 cycles after the raw SDA edge, with SCL held high.
- FSM states IDLE, ADDR, HOLD:
  - Any START, in any state: clear bit count, shift register, address_match, match_idx and general_call; go to ADDR; bus_busy = 1.
  - ADDR: on each SCL rise, shift sda_f in MSB-first and increment the 3-bit count.
  - ADDR, 8th rise: load starting_byte and rw_mode, evaluate match, pulse addr_valid, go to HOLD. The 9th (ACK) clock is ignored.
  - HOLD: outputs held until START or STOP.
  - STOP, in any state: go to IDLE, bus_busy = 0, clear address_match/match_idx/general_call. starting_byte and rw_mode are retained.
  - A STOP or START during ADDR aborts the byte: no addr_valid.
- Match rule:
  - Compare byte[7:1] with every slot.
  - If several slots match, the lowest index wins.
  - address_match = (match_idx != 0).
  - Outputs become valid in the same cycle as addr_valid.
- Simultaneous START and SCL rise cannot occur, because START requires SCL high in both samples.
- Asynchronous rst mid-transfer returns everything to reset values. The next transaction needs a fresh START.

Optional Feature:
- Macro: I2C_GENERAL_CALL_EN
- Defined: a captured byte of 8'h00 sets general_call = 1 and address_match = 1, with match_idx = 0. A real slot match takes precedence: general_call is then 0.
- Undefined: general_call is tied 0, and 8'h00 matches only if a slot holds 7'h00.

Decomposition:
- Package i2c_pkg holds:
  - typedef enum logic [1:0] {IDLE, ADDR, HOLD} i2c_dec_state_t
  - localparam I2C_ADDR_W = 7
  - localparam I2C_GENCALL_BYTE = 8'h00
- Sub-module i2c_line_filter (sync chain plus glitch counter, parametrised by SYNC_STAGES and FILTER_LEN), instantiated once for SCL and once for SDA.

Test Plan:
- Address match: slots {0x50, 0x3C, 0x1A} (slot0 = 0x1A). START then byte 0x79 -> start_found pulse at latency 6 (defaults), addr_valid after 8th SCL rise, match_idx = 2, rw_mode = 1, address_match = 1, bus_busy = 1. Then STOP -> stop_found, address_match = 0, bus_busy = 0.
- Priority and no-match: slots 0 and 2 both 0x1A, byte 0x34 -> match_idx = 1. Byte 0xFE -> match_idx = 0, address_match = 0, addr_valid still pulses.
- Glitch rejection: SCL high, SDA low for 2 cycles -> no start_found. SDA low for 3 cycles -> start_found.
- Repeated START after 4 address bits, then full byte 0x20 -> no addr_valid for the aborted byte, start_found twice, final starting_byte = 0x20.
- Reset mid-ADDR after 5 bits -> all outputs 0. Bits clocked before a new START are ignored. A following clean transaction matches normally.
- Build with I2C_GENERAL_CALL_EN, byte 0x00, no slot = 0 -> general_call = 1, address_match = 1, match_idx = 0. Build without the macro -> address_match = 0.

Source files
------------

// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared types and constants for the I2C slave address front end.
//   i2c_dec_state_t  : address-decoder FSM state (IDLE / ADDR / HOLD)
//   I2C_ADDR_W       : width of a 7-bit I2C device address
//   I2C_GENCALL_BYTE : first byte value that denotes a general call
// -----------------------------------------------------------------------------
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    HOLD = 2'd2
  } i2c_dec_state_t;

  localparam int         I2C_ADDR_W       = 7;
  localparam logic [7:0] I2C_GENCALL_BYTE = 8'h00;

endpackage

// File: rtl/i2c_line_filter.sv
// -----------------------------------------------------------------------------
// i2c_line_filter
// Synchroniser plus glitch filter for one open-drain I2C line.
// The filtered output follows the synchronised input only after FILTER_LEN
// consecutive cycles of disagreement with the current filtered value; any
// return to agreement restarts the count, so shorter pulses are never seen.
// Ports:
//   clk  : system clock
//   rst  : asynchronous, active-high reset
//   raw  : raw line from the pad
//   filt : synchronised, glitch-filtered line (resets to 1, idle bus)
// -----------------------------------------------------------------------------
module i2c_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filt
);

  localparam int                CNT_W   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what makes the chain a chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: synchroniser and filtered line reset to 1 (released bus), so
      // leaving reset never looks like a falling SDA edge.
      sync_q <= '1;
      cnt_q  <= '0;
      filt   <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      if (synced == filt) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        filt  <= synced;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_addr_decoder.sv
// -----------------------------------------------------------------------------
// i2c_addr_decoder
// I2C slave front end: filters SCL/SDA, detects START / repeated START / STOP,
// shifts in the first byte after each START and matches its 7-bit address
// against NUM_ADDR programmable slots (lowest matching slot wins).
// Optional feature macro: I2C_GENERAL_CALL_EN -- when defined, a first byte of
// 8'h00 with no slot match raises general_call and address_match.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   scl, sda_in    : raw I2C lines
//   device_addr    : packed slot addresses, slot i = [7i+6:7i]
//   starting_byte  : first byte captured after the latest START (held)
//   rw_mode        : starting_byte[0] (held)
//   address_match  : level, captured address matched
//   match_idx      : 0 = no match, i+1 = slot i matched
//   addr_valid     : one-cycle pulse when the 8th address bit is sampled
//   start_found    : one-cycle pulse on START / repeated START
//   stop_found     : one-cycle pulse on STOP
//   bus_busy       : level, START until STOP
//   general_call   : general-call flag (tied 0 without the macro)
// -----------------------------------------------------------------------------
module i2c_addr_decoder
  import i2c_pkg::*;
#(
  parameter int NUM_ADDR    = 3,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            scl,
  input  logic                            sda_in,
  input  logic [NUM_ADDR*I2C_ADDR_W-1:0]  device_addr,
  output logic [7:0]                      starting_byte,
  output logic                            rw_mode,
  output logic                            address_match,
  output logic [$clog2(NUM_ADDR+1)-1:0]   match_idx,
  output logic                            addr_valid,
  output logic                            start_found,
  output logic                            stop_found,
  output logic                            bus_busy,
  output logic                            general_call
);

  localparam int IDX_W = $clog2(NUM_ADDR + 1);

  logic scl_f, sda_f, scl_d, sda_d;
  logic start_cond, stop_cond, scl_rise;
  logic do_shift, do_load;
  logic gc_next, am_next;

  i2c_dec_state_t   state_q, state_next;
  logic [2:0]       bit_cnt_q;
  logic [6:0]       shift_q;
  logic [7:0]       cap_byte;
  logic [IDX_W-1:0] match_next;

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk  (clk),
    .rst  (rst),
    .raw  (scl),
    .filt (scl_f)
  );

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk  (clk),
    .rst  (rst),
    .raw  (sda_in),
    .filt (sda_f)
  );

  // Delayed copies of the filtered lines for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  // SCL high in both samples makes START/STOP mutually exclusive with a rise.
  assign start_cond = scl_f & scl_d &  sda_d & ~sda_f;
  assign stop_cond  = scl_f & scl_d & ~sda_d &  sda_f;
  assign scl_rise   = ~scl_d & scl_f;

  // Byte as it will be once the bit currently on sda_f is shifted in.
  assign cap_byte = {shift_q, sda_f};

  // Lowest index wins: scan downwards so the last hit is the smallest slot.
  always_comb begin
    // NOTE: default assignment first so no path leaves the variable unassigned
    // (which would infer a latch).
    match_next = '0;
    for (int i = NUM_ADDR - 1; i >= 0; i--) begin
      if (device_addr[i*I2C_ADDR_W +: I2C_ADDR_W] == cap_byte[7:1]) begin
        match_next = IDX_W'(i + 1);
      end
    end
  end

`ifdef I2C_GENERAL_CALL_EN
  // A real slot match takes precedence over the general call.
  assign gc_next = (match_next == '0) && (cap_byte == I2C_GENCALL_BYTE);
`else
  assign gc_next = 1'b0;
`endif

  assign am_next = (match_next != '0) | gc_next;

  // FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_next;
  end

  // FSM: next state. START and STOP are honoured in every state.
  always_comb begin
    state_next = state_q;
    if (start_cond) begin
      state_next = ADDR;
    end else if (stop_cond) begin
      state_next = IDLE;
    end else if (state_q == ADDR && scl_rise && bit_cnt_q == 3'd7) begin
      state_next = HOLD;
    end
  end

  // FSM: datapath controls.
  always_comb begin
    do_shift = (state_q == ADDR) && scl_rise && !start_cond && !stop_cond;
    do_load  = do_shift && (bit_cnt_q == 3'd7);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      starting_byte <= '0;
      rw_mode       <= 1'b0;
      address_match <= 1'b0;
      match_idx     <= '0;
      addr_valid    <= 1'b0;
    end else begin
      addr_valid <= do_load;
      if (start_cond) begin
        bit_cnt_q     <= '0;
        shift_q       <= '0;
        address_match <= 1'b0;
        match_idx     <= '0;
      end else if (stop_cond) begin
        // Captured byte and R/W bit stay visible after STOP.
        address_match <= 1'b0;
        match_idx     <= '0;
      end else if (do_shift) begin
        shift_q   <= cap_byte[6:0];
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (do_load) begin
          starting_byte <= cap_byte;
          rw_mode       <= cap_byte[0];
          address_match <= am_next;
          match_idx     <= match_next;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_found <= 1'b0;
      stop_found  <= 1'b0;
      bus_busy    <= 1'b0;
    end else begin
      start_found <= start_cond;
      stop_found  <= stop_cond;
      if (start_cond)     bus_busy <= 1'b1;
      else if (stop_cond) bus_busy <= 1'b0;
    end
  end

`ifdef I2C_GENERAL_CALL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         general_call <= 1'b0;
    else if (start_cond | stop_cond) general_call <= 1'b0;
    else if (do_load)                general_call <= gc_next;
  end
`else
  assign general_call = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_addr_decoder.sv
// -----------------------------------------------------------------------------
// tb_i2c_addr_decoder
// Self-checking bench for i2c_addr_decoder with default parameters.
// Expected first-byte results are queued when a byte is driven and compared
// when the DUT pulses addr_valid; pulse counts and levels are checked between
// directed steps. Honours I2C_GENERAL_CALL_EN for the general-call step.
// -----------------------------------------------------------------------------
module tb_i2c_addr_decoder;

  localparam int NUM_ADDR = 3;
  localparam int IDX_W    = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 scl;
  logic                 sda_in;
  logic [NUM_ADDR*7-1:0] device_addr;
  logic [7:0]           starting_byte;
  logic                 rw_mode;
  logic                 address_match;
  logic [IDX_W-1:0]     match_idx;
  logic                 addr_valid;
  logic                 start_found;
  logic                 stop_found;
  logic                 bus_busy;
  logic                 general_call;

  always #5 clk = ~clk;

  i2c_addr_decoder #(.NUM_ADDR(NUM_ADDR), .SYNC_STAGES(2), .FILTER_LEN(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .scl           (scl),
    .sda_in        (sda_in),
    .device_addr   (device_addr),
    .starting_byte (starting_byte),
    .rw_mode       (rw_mode),
    .address_match (address_match),
    .match_idx     (match_idx),
    .addr_valid    (addr_valid),
    .start_found   (start_found),
    .stop_found    (stop_found),
    .bus_busy      (bus_busy),
    .general_call  (general_call)
  );

  typedef struct {
    logic [7:0]       b;
    logic [IDX_W-1:0] idx;
    logic             am;
    logic             gc;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   start_cnt   = 0;
  int   stop_cnt    = 0;
  int   av_cnt      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: counts pulses and scores each addr_valid against the queue.
  exp_t e;
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (start_found === 1'b1) start_cnt++;
      if (stop_found === 1'b1)  stop_cnt++;
      if (addr_valid === 1'b1) begin
        av_cnt++;
        if (sb.size() == 0) begin
          check("sb_entry_for_addr_valid", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check("sb_starting_byte", 32'(starting_byte), 32'(e.b));
          check("sb_rw_mode",       32'(rw_mode),       32'(e.b[0]));
          check("sb_match_idx",     32'(match_idx),     32'(e.idx));
          check("sb_address_match", 32'(address_match), 32'(e.am));
          check("sb_general_call",  32'(general_call),  32'(e.gc));
          check("sb_bus_busy",      32'(bus_busy),      32'd1);
        end
      end
    end
  end

  function automatic logic [31:0] all_outputs();
    return 32'({starting_byte, rw_mode, address_match, match_idx,
                addr_valid, start_found, stop_found, bus_busy, general_call});
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives a (repeated) START and reports cycles from SDA fall to start_found.
  task automatic send_start(output int lat);
    sda_in = 1'b1;
    wait_cyc(8);
    scl = 1'b1;
    wait_cyc(10);
    sda_in = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (start_found === 1'b1 && lat < 0) lat = i;
    end
    scl = 1'b0;
    wait_cyc(8);
  endtask

  task automatic send_bit(input logic b);
    sda_in = b;
    wait_cyc(8);
    scl = 1'b1;
    wait_cyc(10);
    scl = 1'b0;
    wait_cyc(8);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_stop();
    sda_in = 1'b0;
    wait_cyc(8);
    scl = 1'b1;
    wait_cyc(10);
    sda_in = 1'b1;
    wait_cyc(12);
  endtask

  task automatic push_exp(input logic [7:0] b, input logic [IDX_W-1:0] idx,
                          input logic am, input logic gc);
    exp_t x;
    x.b = b; x.idx = idx; x.am = am; x.gc = gc;
    sb.push_back(x);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int s0, p0, a0;

    // Reset state.
    rst = 1'b1; scl = 1'b1; sda_in = 1'b1;
    device_addr = {7'h50, 7'h3C, 7'h1A};
    wait_cyc(3);
    check("outputs_in_reset", all_outputs(), 32'd0);
    rst = 1'b0;
    wait_cyc(10);
    check("outputs_after_reset", all_outputs(), 32'd0);

    // Address match: 0x79 -> address 0x3C -> slot 1, read.
    send_start(lat);
    check("start_latency", 32'(lat), 32'd6);
    check("start_count_1", 32'(start_cnt), 32'd1);
    check("busy_after_start", 32'(bus_busy), 32'd1);
    push_exp(8'h79, 2'd2, 1'b1, 1'b0);
    send_byte(8'h79);
    check("addr_valid_count_1", 32'(av_cnt), 32'd1);
    send_bit(1'b0); // ACK clock, ignored
    check("ack_clock_ignored", 32'(av_cnt), 32'd1);
    check("hold_match_idx", 32'(match_idx), 32'd2);
    check("hold_address_match", 32'(address_match), 32'd1);
    send_stop();
    check("stop_count_1", 32'(stop_cnt), 32'd1);
    check("stop_address_match", 32'(address_match), 32'd0);
    check("stop_match_idx", 32'(match_idx), 32'd0);
    check("stop_bus_busy", 32'(bus_busy), 32'd0);
    check("stop_keeps_byte", 32'(starting_byte), 32'h79);
    check("stop_keeps_rw", 32'(rw_mode), 32'd1);

    // Priority: slots 0 and 2 both 0x1A; 0x34 -> slot 0.
    device_addr = {7'h1A, 7'h3C, 7'h1A};
    push_exp(8'h34, 2'd1, 1'b1, 1'b0);
    send_start(lat);
    send_byte(8'h34);
    send_stop();
    // No match: 0xFE -> address 0x7F.
    push_exp(8'hFE, 2'd0, 1'b0, 1'b0);
    send_start(lat);
    send_byte(8'hFE);
    check("nomatch_address_match", 32'(address_match), 32'd0);
    send_stop();
    check("addr_valid_count_3", 32'(av_cnt), 32'd3);

    // Glitch rejection on SDA with SCL high.
    s0 = start_cnt; p0 = stop_cnt;
    sda_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 sda_in = 1'b1;
    wait_cyc(15);
    check("glitch2_no_start", 32'(start_cnt - s0), 32'd0);
    check("glitch2_not_busy", 32'(bus_busy), 32'd0);
    sda_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 sda_in = 1'b1;
    wait_cyc(15);
    check("glitch3_start", 32'(start_cnt - s0), 32'd1);
    check("glitch3_stop", 32'(stop_cnt - p0), 32'd1);

    // Repeated START after 4 address bits aborts the byte.
    s0 = start_cnt; a0 = av_cnt;
    send_start(lat);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    check("abort_no_addr_valid", 32'(av_cnt - a0), 32'd0);
    send_start(lat);
    check("rstart_latency", 32'(lat), 32'd6);
    push_exp(8'h20, 2'd0, 1'b0, 1'b0);
    send_byte(8'h20);
    check("rstart_start_count", 32'(start_cnt - s0), 32'd2);
    check("rstart_addr_valid", 32'(av_cnt - a0), 32'd1);
    check("rstart_byte", 32'(starting_byte), 32'h20);
    send_stop();

    // Asynchronous reset after 5 address bits.
    send_start(lat);
    push_exp(8'h35, 2'd1, 1'b1, 1'b0);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    rst = 1'b1;
    #2;
    check("midaddr_reset_outputs", all_outputs(), 32'd0);
    wait_cyc(3);
    rst = 1'b0;
    a0 = av_cnt;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    check("post_reset_bits_ignored", 32'(av_cnt - a0), 32'd0);
    check("post_reset_not_busy", 32'(bus_busy), 32'd0);
    send_start(lat);
    send_byte(8'h35);
    check("post_reset_match", 32'(av_cnt - a0), 32'd1);
    send_stop();

    // General call byte, no slot holds 0x00.
`ifdef I2C_GENERAL_CALL_EN
    push_exp(8'h00, 2'd0, 1'b1, 1'b1);
`else
    push_exp(8'h00, 2'd0, 1'b0, 1'b0);
`endif
    send_start(lat);
    send_byte(8'h00);
    send_stop();
    check("general_call_cleared_by_stop", 32'(general_call), 32'd0);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
